gf16_reduce_pipe: RTL

- Pipelined GF(2^16) modular reduction stage placed directly downstream of the 16-bit overlap-free Karatsuba polynomial multiplier.
- Consumes the 31-bit carry-less product, reduces it modulo x^16 + P(x), and emits the 16-bit field element.
- P(x) is runtime-configurable.
- Valid/ready handshake on both sides; 2-stage pipeline with full-throughput backpressure.

---
 rtl/gf16_reduce_pipe_pkg.sv | 36 +++
 rtl/gf16_reduce_pipe_fold_stage.sv | 56 +++++
 rtl/gf16_reduce_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/gf16_reduce_pipe_pkg.sv
// Shared GF(2^16) constants and the ordered fold used by both reduction stages.
// x^16 is implicit in every polynomial value; only the low 16 coefficients are carried.
package gf_pkg;

    localparam int GF_M   = 16;
    localparam int PROD_W = 2 * GF_M - 1;

    // Stage 1 folds 30..23, which leaves 23 significant bits for stage 2.
    localparam int S1_K_HI = PROD_W - 1;
    localparam int S1_K_LO = 23;
    localparam int S1_W    = S1_K_LO;
    localparam int S2_K_HI = S1_K_LO - 1;
    localparam int S2_K_LO = GF_M;

    localparam logic [GF_M-1:0] GF_DEFAULT_POLY = 16'h002D;

    // Fold steps run strictly high-to-low.  A fold at k can re-raise lower bits,
    // which are then handled by later (lower) steps in this range or the next stage.
    function automatic logic [PROD_W-1:0] gf_fold(
        input logic [PROD_W-1:0] value,
        input logic [GF_M-1:0]   poly,
        input int                k_hi,
        input int                k_lo
    );
        logic [PROD_W-1:0] v;
        v = value;
        for (int k = PROD_W - 1; k >= GF_M; k--) begin
            if (k <= k_hi && k >= k_lo && v[k]) begin
                v    = v ^ ({{(PROD_W-GF_M){1'b0}}, poly} << (k - GF_M));
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/gf16_reduce_pipe_fold_stage.sv
// One pipeline stage: combinational fold over [K_HI:K_LO] feeding a valid/ready
// register slice that accepts whenever it is empty or its output is being taken.
module gf_fold_stage
    import gf_pkg::*;
#(
    parameter int IN_W  = PROD_W,
    parameter int OUT_W = S1_W,
    parameter int K_HI  = S1_K_HI,
    parameter int K_LO  = S1_K_LO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [GF_M-1:0]  poly,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    logic [PROD_W-1:0] fold_in;
    logic [PROD_W-1:0] fold_out;
    logic [OUT_W-1:0]  data_d;
    logic [OUT_W-1:0]  data_q;
    logic              valid_q;
    logic              unused_hi;

    always_comb begin
        fold_in             = '0;
        fold_in[IN_W-1:0]   = in_data;
        fold_out            = gf_fold(fold_in, poly, K_HI, K_LO);
    end

    // Bits above OUT_W are zero after the fold by construction.
    assign data_d    = fold_out[OUT_W-1:0];
    assign unused_hi = ^fold_out[PROD_W-1:OUT_W];

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= data_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gf16_reduce_pipe.sv
// Two-stage GF(2^16) reduction of a 31-bit carry-less product modulo x^16 + P(x),
// with a runtime-writable P snapshotted per sample so config writes never touch in-flight data.
module gf16_reduce_pipe
    import gf_pkg::*;
#(
    parameter logic [GF_M-1:0] RST_POLY = GF_DEFAULT_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              cfg_we,
    input  logic [GF_M-1:0]   cfg_poly,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GF_M-1:0]   out_res,
    output logic              busy
);

    logic [GF_M-1:0] poly_q;
    logic [GF_M-1:0] poly_d;
    logic [GF_M-1:0] s1_poly_q;
    logic            accept;
    logic            s1_valid;
    logic            s2_ready;
    logic [S1_W-1:0] s1_data;

    assign accept = in_valid && in_ready;
    assign poly_d = cfg_we ? cfg_poly : poly_q;

    // The snapshot takes the pre-write value, so a same-cycle cfg_we only affects later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poly_q    <= RST_POLY;
            s1_poly_q <= '0;
        end else begin
            poly_q <= poly_d;
            if (accept) begin
                s1_poly_q <= poly_q;
            end
        end
    end

    gf_fold_stage #(
        .IN_W  (PROD_W),
        .OUT_W (S1_W),
        .K_HI  (S1_K_HI),
        .K_LO  (S1_K_LO)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_prod),
        .poly      (poly_q),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    gf_fold_stage #(
        .IN_W  (S1_W),
        .OUT_W (GF_M),
        .K_HI  (S2_K_HI),
        .K_LO  (S2_K_LO)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s1_data),
        .poly      (s1_poly_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_res)
    );

    assign busy = s1_valid || out_valid;

endmodule
